// File: rtl/ram_io_pkg.sv
// Shared types and address decoding for ram_io_unit.
package ram_io_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        CLS_RAM,
        CLS_IO_OUT,
        CLS_IO_IN,
        CLS_STATUS
    } addr_class_e;

    // Windows are laid out back to back from io_base: outputs, inputs, then the optional status word.
    function automatic addr_class_e decode_addr(
        input int unsigned addr,
        input int unsigned io_base,
        input int unsigned num_out,
        input int unsigned num_in,
        input bit          status_en
    );
        if (addr >= io_base && addr < io_base + num_out)
            return CLS_IO_OUT;
        if (addr >= io_base + num_out && addr < io_base + num_out + num_in)
            return CLS_IO_IN;
        if (status_en && addr == io_base + num_out + num_in)
            return CLS_STATUS;
        return CLS_RAM;
    endfunction

endpackage

// File: rtl/ram_io_unit_io_in_sync.sv
// Two-flop synchroniser for the packed external input bus.
module io_in_sync #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ram_io_unit.sv
// Data RAM with memory-mapped I/O window and post-reset clear sequencer.
// Optional sticky input-change status word: define RAM_IO_CHANGE_FLAG_EN.
module ram_io_unit
    import ram_io_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned IO_BASE = 64,
    parameter int unsigned NUM_OUT = 1,
    parameter int unsigned NUM_IN  = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [ADDR_W-1:0]         RAM_ADDR,
    input  logic [DATA_W-1:0]         RAM_IN,
    input  logic                      RAM_WEN,
    input  logic                      RAM_REN,
    output logic [DATA_W-1:0]         RAM_OUT,
    input  logic [NUM_IN*DATA_W-1:0]  IO_IN,
    output logic [NUM_OUT*DATA_W-1:0] IO_OUT,
    output logic                      BUSY
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_IO_CHANGE_FLAG_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif
    localparam int unsigned WIN_END = IO_BASE + NUM_OUT + NUM_IN + (STATUS_EN ? 1 : 0);

    if (WIN_END > DEPTH) begin : g_bad_window
        $error("ram_io_unit: I/O window exceeds address space");
    end
    if (NUM_OUT < 1 || NUM_IN < 1) begin : g_bad_ports
        $error("ram_io_unit: NUM_OUT and NUM_IN must be at least 1");
    end
    if (STATUS_EN && NUM_IN > DATA_W) begin : g_bad_flags
        $error("ram_io_unit: NUM_IN exceeds DATA_W with change flags enabled");
    end

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]          ram_out_q, ram_out_d;
    logic [NUM_OUT*DATA_W-1:0]  io_out_q, io_out_d;
    logic [DATA_W-1:0]          mem_q [DEPTH];

    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_waddr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [NUM_IN*DATA_W-1:0]   io_in_sync_val;
    logic [DATA_W-1:0]          status_word;
    logic [DATA_W-1:0]          rd_word;
    logic                       run_load;
    int unsigned                addr_int;
    addr_class_e                addr_cls;

    io_in_sync #(
        .WIDTH(NUM_IN * DATA_W)
    ) u_io_in_sync (
        .clk(CLK),
        .rst(RST),
        .d  (IO_IN),
        .q  (io_in_sync_val)
    );

    always_comb begin
        addr_int = 32'(RAM_ADDR);
        addr_cls = decode_addr(addr_int, IO_BASE, NUM_OUT, NUM_IN, STATUS_EN);
        run_load = (state_q == ST_RUN) && RAM_REN;
    end

`ifdef RAM_IO_CHANGE_FLAG_EN
    logic [NUM_IN-1:0]        flags_q, flags_d, chg;
    logic [NUM_IN*DATA_W-1:0] prev_q, prev_d;

    // Read-clear is applied before the new changes so a coincident change stays set.
    always_comb begin
        prev_d = io_in_sync_val;
        for (int unsigned i = 0; i < NUM_IN; i++)
            chg[i] = (io_in_sync_val[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
        flags_d = flags_q;
        if (run_load && addr_cls == CLS_STATUS)
            flags_d = '0;
        flags_d = flags_d | chg;
        status_word = '0;
        status_word[NUM_IN-1:0] = flags_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags_q <= '0;
            prev_q  <= '0;
        end else begin
            flags_q <= flags_d;
            prev_q  <= prev_d;
        end
    end
`else
    assign status_word = '0;
`endif

    always_comb begin
        rd_word = '0;
        case (addr_cls)
            CLS_RAM:
                rd_word = RAM_WEN ? RAM_IN : mem_q[RAM_ADDR];
            CLS_IO_OUT:
                for (int unsigned i = 0; i < NUM_OUT; i++)
                    if (addr_int == IO_BASE + i)
                        rd_word = RAM_WEN ? RAM_IN : io_out_q[i*DATA_W +: DATA_W];
            CLS_IO_IN:
                for (int unsigned i = 0; i < NUM_IN; i++)
                    if (addr_int == IO_BASE + NUM_OUT + i)
                        rd_word = io_in_sync_val[i*DATA_W +: DATA_W];
            default:
                rd_word = status_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_out_d = ram_out_q;
        io_out_d  = io_out_q;
        mem_we    = 1'b0;
        mem_waddr = RAM_ADDR;
        mem_wdata = RAM_IN;

        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1)
                state_d = ST_RUN;
        end else begin
            if (RAM_WEN) begin
                if (addr_cls == CLS_RAM)
                    mem_we = 1'b1;
                for (int unsigned i = 0; i < NUM_OUT; i++)
                    if (addr_cls == CLS_IO_OUT && addr_int == IO_BASE + i)
                        io_out_d[i*DATA_W +: DATA_W] = RAM_IN;
            end
            if (RAM_REN)
                ram_out_d = rd_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ram_out_q <= '0;
            io_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ram_out_q <= ram_out_d;
            io_out_q  <= io_out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign RAM_OUT = ram_out_q;
    assign IO_OUT  = io_out_q;
    assign BUSY    = (state_q == ST_CLEAR);

endmodule

// File: doc/ram_io_unit.md
Name: ram_io_unit

Overview:
Single-clock, parametrised data memory with a memory-mapped I/O window; successor to the split-clock decode/write-back RAM in the CPU15 datapath. Serves CPU loads and stores with registered 1-cycle read latency. Decodes a contiguous I/O window into NUM_OUT output registers and NUM_IN synchronised input ports. A hardware clear sequencer zeroes the RAM after reset.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, address width; RAM depth = 2**ADDR_W
IO_BASE, 64, first address of the I/O window
NUM_OUT, 1, output registers at IO_BASE .. IO_BASE+NUM_OUT-1
NUM_IN, 1, input ports at IO_BASE+NUM_OUT .. IO_BASE+NUM_OUT+NUM_IN-1

Ports:
CLK  in  1  single clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
RAM_ADDR  in  ADDR_W  access address
RAM_IN  in  DATA_W  store data
RAM_WEN  in  1  store enable
RAM_REN  in  1  load enable; RAM_OUT holds when low
RAM_OUT  out  DATA_W  load data, registered
IO_IN  in  NUM_IN*DATA_W  external inputs; port i = bits [i*DATA_W +: DATA_W]
IO_OUT  out  NUM_OUT*DATA_W  output registers; same packing
BUSY  out  1  high while clear sequencer runs

Behaviour:
- Reset (async, RST=1): RAM_OUT=0, IO_OUT=0, sync flops=0, BUSY=1, FSM=CLEAR, clear counter=0. RAM contents not reset directly.
- FSM states: CLEAR, RUN.
- CLEAR: one RAM word zeroed per cycle at counter address; counter increments.
- CLEAR: after writing address 2**ADDR_W-1, go to RUN. BUSY low from the following cycle. Total BUSY = 2**ADDR_W cycles after RST release.
- CLEAR: RAM_WEN/RAM_REN ignored; RAM_OUT held at 0.
- RST asserted mid-CLEAR: counter restarts at 0.
- RUN: FSM stays in RUN until RST.
- Store (RUN, RAM_WEN=1):
  - address in output window: the addressed IO_OUT slot updates on that edge.
  - address in input window: discarded.
  - all other addresses: RAM written. I/O addresses never write RAM.
- Load (RUN, RAM_REN=1): RAM_OUT updates on the same edge with:
  - RAM word, output-register value, or synchronised input value, per address.
  - same-cycle store to the same address: new RAM_IN value returned (write-first).
- RAM_REN=0: RAM_OUT holds its previous value.
- Input path: IO_IN passes through a 2-flop synchroniser. A value stable before edge k is readable by a load sampled at edge k+2; visible on RAM_OUT after that edge.
- Legal parameter range: window end ≤ 2**ADDR_W, plus 1 if the optional feature is on. Elaboration $error otherwise.
- Address wrap: none; ADDR_W bits fully decode the space.

Optional Feature:
RAM_IO_CHANGE_FLAG_EN:
- Defined:
  - status word at IO_BASE+NUM_OUT+NUM_IN; bit i is a sticky flag, set when synchronised input i differs from its previous cycle.
  - a load of the status address returns the flags and clears them on the same edge.
  - a flag setting on that same edge wins: it stays 1.
  - requires NUM_IN ≤ DATA_W.
  - reset clears all flags.
- Undefined: no status address; that address is ordinary RAM.

Decomposition:
- Package ram_io_pkg: FSM state enum (CLEAR, RUN); address-class enum (RAM, IO_OUT, IO_IN, STATUS); decode function computing the class from address and parameters.
- One sub-module io_in_sync: parametrised-width 2-flop synchroniser with async active-high reset, instantiated once over the packed IO_IN bus.

Test Plan:
- Clear: RST pulse, preload garbage via backdoor → BUSY high exactly 256 cycles. Loads of addresses 0, 37, 255 return 0. Stores during BUSY have no effect.
- RAM load/store: store 0x0002..0x0010 to addresses 0..7, then load back → each value on RAM_OUT one edge after the load. Store and load of address 9 on the same edge with 0x1234 → 0x1234.
- Output window: store 0xBEEF to 64 → IO_OUT=0xBEEF after that edge. Loading 64 → 0xBEEF. RAM shadow word at 64 stays 0.
- Input window: IO_IN=0x00A5 changed before edge k, loads of 65 at k, k+1, k+2 → old, old, 0x00A5. Store to 65 → ignored.
- RST mid-clear at cycle 100, then release → BUSY lasts a full 256 cycles from release. Asserting RST during RUN → IO_OUT=0 asynchronously.
- With RAM_IO_CHANGE_FLAG_EN: toggle IO_IN → load 66 returns 0x0001, next load returns 0x0000. Change coincident with the read → flag remains 1.
